// File: rtl/eqv_pkg.sv
// Shared definitions for the equivalence checker: FSM states and minterm helpers.
package eqv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int NUM_MINTERMS = 16;

  // One-hot mask selecting the coverage bit for a 4-input minterm.
  function automatic logic [NUM_MINTERMS-1:0] minterm_mask(input logic [3:0] idx);
    logic [NUM_MINTERMS-1:0] one;
    one = {{(NUM_MINTERMS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {WIDTH{1'b1}})) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/eqv_checker.sv
// Compares two 4-input implementations vector by vector, tracking minterm
// coverage, mismatch count and the first failing minterm for each run.
module eqv_checker
  import eqv_pkg::*;
#(
  parameter int MAX_VECS = 64,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    valid,
  input  logic [3:0]              abcd,
  input  logic                    f_a,
  input  logic                    f_b,
  output logic                    busy,
  output logic                    mismatch,
  output logic [CNT_W-1:0]        vec_count,
  output logic [CNT_W-1:0]        err_count,
  output logic [NUM_MINTERMS-1:0] coverage,
  output logic [3:0]              first_bad,
  output logic                    first_bad_vld,
  output logic                    done,
  output logic                    pass
);

  state_e                  state_q, state_d;
  logic [NUM_MINTERMS-1:0] cov_q, cov_d;
  logic [3:0]              first_bad_q, first_bad_d;
  logic                    fbv_q, fbv_d;
  logic                    mismatch_q, mismatch_d;
  logic                    accept, is_bad, last_vec;

  // start wins over a coincident valid, so that vector never reaches the counters.
  assign accept   = (state_q == RUN) && valid && !start;
  assign is_bad   = f_a != f_b;
  assign last_vec = vec_count == CNT_W'(MAX_VECS - 1);

  sat_counter #(.WIDTH(CNT_W)) u_vec_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (accept),
    .q   (vec_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (accept && is_bad),
    .q   (err_count)
  );

  always_comb begin
    state_d     = state_q;
    cov_d       = cov_q;
    first_bad_d = first_bad_q;
    fbv_d       = fbv_q;
    mismatch_d  = 1'b0;
    if (start) begin
      state_d     = RUN;
      cov_d       = '0;
      first_bad_d = '0;
      fbv_d       = 1'b0;
    end else if (accept) begin
      cov_d      = cov_q | minterm_mask(abcd);
      mismatch_d = is_bad;
      if (is_bad && !fbv_q) begin
        first_bad_d = abcd;
        fbv_d       = 1'b1;
      end
      // The terminating vector is still counted and checked above.
      if (last_vec || (cov_d == {NUM_MINTERMS{1'b1}})) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cov_q       <= '0;
      first_bad_q <= '0;
      fbv_q       <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cov_q       <= cov_d;
      first_bad_q <= first_bad_d;
      fbv_q       <= fbv_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign busy          = state_q == RUN;
  assign done          = state_q == DONE;
  assign pass          = done && (err_count == '0);
  assign mismatch      = mismatch_q;
  assign coverage      = cov_q;
  assign first_bad     = first_bad_q;
  assign first_bad_vld = fbv_q;

endmodule

// File: doc/eqv_checker.md
EQV_CHECKER -- requirements
Module: eqv_checker

Interface
REQ-001 Parameter MAX_VECS, default 64: vector budget per run; run ends when this many vectors have been accepted.
REQ-002 Parameter CNT_W, default 8: width of all counters; MAX_VECS SHALL be at most 2^CNT_W-1.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that clears results and begins a run.
REQ-006 valid  input  1  the current abcd/f_a/f_b are a vector to check.
REQ-007 abcd  input  4  stimulus {A,B,C,D}, A is MSB.
REQ-008 f_a  input  1  response of implementation A.
REQ-009 f_b  input  1  response of implementation B.
REQ-010 busy  output  1  high while in RUN.
REQ-011 mismatch  output  1  one-cycle pulse per mismatching vector.
REQ-012 vec_count  output  CNT_W  number of vectors accepted this run.
REQ-013 err_count  output  CNT_W  number of mismatching vectors this run, saturating.
REQ-014 coverage  output  16  bit i is set once abcd==i has been accepted this run.
REQ-015 first_bad  output  4  abcd of the first mismatching vector.
REQ-016 first_bad_vld  output  1  first_bad holds a captured value.
REQ-017 done  output  1  high in DONE.
REQ-018 pass  output  1  done AND err_count==0.

Function
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 IDLE: start -> RUN; valid is ignored.
REQ-021 RUN: a vector is accepted on a rising edge when valid=1 and start=0.
REQ-022 Accepting a vector increments vec_count and sets coverage[abcd], both visible the next cycle.
REQ-023 An accepted vector with f_a!=f_b asserts mismatch for exactly the next cycle and increments err_count, holding at 2^CNT_W-1.
REQ-024 The first mismatch of a run loads first_bad and sets first_bad_vld; later mismatches leave both unchanged.
REQ-025 RUN -> DONE on the edge that accepts vector number MAX_VECS, or on the edge where coverage becomes all ones, whichever comes first.
REQ-026 The vector accepted on the RUN -> DONE edge is fully counted and checked.
REQ-027 DONE: all results hold; valid is ignored; start -> RUN.
REQ-028 start in any state clears vec_count, err_count, coverage, first_bad, first_bad_vld and mismatch, then enters RUN.
REQ-029 start takes priority over a simultaneous valid; that vector is discarded.
REQ-030 Every output is a registered output, with no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 immediately forces IDLE and drives every output and counter to 0, independent of clk.
REQ-032 rst asserted during RUN abandons the run; after release the block waits in IDLE for start.

Structure
REQ-033 Shared package eqv_pkg holds the state enum (IDLE/RUN/DONE) and the constant NUM_MINTERMS=16.
REQ-034 One sub-module, sat_counter (parameter width; inputs clr, inc; output q), implements both vec_count and err_count; it saturates at all-ones.

Verification
REQ-035 start, then 16 vectors abcd=0..15 with f_a==f_b -> done on the edge accepting abcd=15, vec_count=16, coverage=16'hFFFF, err_count=0, pass=1.
REQ-036 MAX_VECS=64, abcd held at 3 with matching responses -> DONE after vector 64, coverage=16'h0008, pass=1.
REQ-037 Mismatches at abcd=5, then at abcd=9 -> two one-cycle mismatch pulses, err_count=2, first_bad=5, first_bad_vld=1, pass=0 when done.
REQ-038 Mismatching vector presented together with start -> vector discarded, err_count=0, vec_count=0 the next cycle.
REQ-039 rst pulsed mid-run after 10 vectors -> all outputs 0 at once and state IDLE; valid without start -> no counting.
REQ-040 CNT_W=4, MAX_VECS=15, 15 mismatches on one repeated minterm -> err_count=15 (saturated), done=1, pass=0.
